// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ps2_pkg;

  // Frame deserialiser states, advanced on each filtered ps2_clk fall.
  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_e;

  // Prefix bytes folded into the following key event.
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // One decoded key event as stored in the FIFO.
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous show-ahead FIFO; the head entry is driven combinationally from registered storage.
// Latency: a push is visible at the head one edge later; a pop updates head and count on the next edge.
// Backpressure: push while full (no pop that cycle) is refused; pop while empty is ignored.
//
// Ports: clock/resetn; push + push_dat in; pop in; head_dat, full, empty, count out.
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  // Last popped entry, shown while empty so the outputs hold their value.
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             push_ok, pop_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign head_dat = empty ? hold_q : mem_q[rd_ptr_q];

  always_comb begin
    pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push while full still lands.
    push_ok = push && (!full || pop_ok);
    mem_d   = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = push_dat;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    hold_d   = pop_ok ? mem_q[rd_ptr_q] : hold_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: sync + glitch filter, 11-bit frame deserialiser, E0/F0 prefix folding, event FIFO.
// Latency: pin fall to internal fall 2+FILTER_LEN cycles; stop-bit fall to FIFO write 1 cycle; key_valid 1 cycle later.
// Backpressure: none toward the keyboard; events queue in the FIFO, overflow drops the event and sets a sticky flag.
//
// Ports: clock/resetn; raw ps2_clk/ps2_dat in; rd_en pops the head; key_code/key_ext/key_break/key_valid/fifo_count
// show the head; overflow/frame_err sticky error flags, cleared by clear_err.
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                            clock,
  input  logic                            resetn,
  input  logic                            ps2_clk,
  input  logic                            ps2_dat,
  input  logic                            rd_en,
  output logic [7:0]                      key_code,
  output logic                            key_ext,
  output logic                            key_break,
  output logic                            key_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overflow,
  output logic                            frame_err,
  input  logic                            clear_err
);

  localparam int             TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]     FLT_LAST  = 8'(FILTER_LEN - 1);
  localparam logic [TW-1:0]  TMO_LIMIT = TW'(TIMEOUT_CYCLES);

  // Lane 0 = ps2_clk, lane 1 = ps2_dat.
  logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d;
  logic [7:0]    cnt_q [2];
  logic [7:0]    cnt_d [2];
  logic          fall, dat_f;

  frame_state_e  state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          byte_vld_q, byte_vld_d;
  logic          ferr_q, ferr_d;

  logic          ext_q, ext_d, brk_q, brk_d;
  logic          overflow_q, overflow_d, frame_err_q, frame_err_d;
  logic          push, fifo_full, fifo_empty;
  key_event_t    push_evt, head_evt;

  // Synchroniser and filter: a lane follows its input only after FILTER_LEN consecutive differing samples.
  always_comb begin
    sync1_d = {ps2_dat, ps2_clk};
    sync2_d = sync1_q;
    filt_d  = filt_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = 8'd0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == FLT_LAST) filt_d[i] = sync2_q[i];
        else                      cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
    fall  = filt_q[0] && !filt_d[0];
    dat_f = filt_q[1];
  end

  // Frame deserialiser. The timeout counter runs only inside a frame and reloads on each fall.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tmo_d      = '0;
    byte_vld_d = 1'b0;
    ferr_d     = 1'b0;
    if (fall) begin
      case (state_q)
        IDLE: if (!dat_f) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
        DATA: begin
          shift_d   = {dat_f, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_f;
          state_d = STOP;
        end
        STOP: begin
          if (dat_f && (^{shift_q, par_q})) byte_vld_d = 1'b1;
          else                              ferr_d     = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_q >= TMO_LIMIT) begin
        ferr_d  = 1'b1;
        state_d = IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  // Prefix decoder and sticky flags. shift_q still holds the finished byte while byte_vld_q is high.
  always_comb begin
    ext_d         = ext_q;
    brk_d         = brk_q;
    push          = 1'b0;
    push_evt.ext  = ext_q;
    push_evt.brk  = brk_q;
    push_evt.code = shift_q;
    if (ferr_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_vld_q) begin
      if (shift_q == PS2_EXT)      ext_d = 1'b1;
      else if (shift_q == PS2_BRK) brk_d = 1'b1;
      else begin
        push  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
    // A new error beats clear_err in the same cycle.
    overflow_d  = (push && fifo_full && !(rd_en && !fifo_empty)) || (overflow_q && !clear_err);
    frame_err_d = ferr_q || (frame_err_q && !clear_err);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      filt_q      <= 2'b11;
      cnt_q[0]    <= 8'd0;
      cnt_q[1]    <= 8'd0;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      byte_vld_q  <= 1'b0;
      ferr_q      <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      byte_vld_q  <= byte_vld_d;
      ferr_q      <= ferr_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (10)
  ) u_fifo (
    .clock    (clock),
    .resetn   (resetn),
    .push     (push),
    .push_dat (push_evt),
    .pop      (rd_en),
    .head_dat (head_evt),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign key_code  = head_evt.code;
  assign key_ext   = head_evt.ext;
  assign key_break = head_evt.brk;
  assign key_valid = !fifo_empty;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/ps2_scan_receiver.md
# ps2_scan_receiver

Parametrised PS/2 keyboard receiver, the next generation of the game's keyboard front end. It filters the raw PS/2 clock and data lines and deframes 11-bit frames with parity and stop checking. It folds E0/F0 prefixes into decoded key events and queues them in a show-ahead FIFO. The control FSM drains the FIFO at its own pace, so no keystroke is lost while it is busy.

## Interface
Parameters:
- FILTER_LEN, 8: consecutive identical samples needed before the filtered ps2_clk/ps2_dat change; range 2..255.
- FIFO_DEPTH, 8: number of key-event entries; must be a power of two, 2..64.
- TIMEOUT_CYCLES, 100000: maximum clock cycles between falling edges inside a frame (2 ms at 50 MHz).

Ports:
- clock, in, 1: system clock (50 MHz); the only clock.
- resetn, in, 1: asynchronous, active-low reset.
- ps2_clk, in, 1: raw PS/2 clock, asynchronous.
- ps2_dat, in, 1: raw PS/2 data, asynchronous.
- rd_en, in, 1: pops the head entry when key_valid=1; ignored when the FIFO is empty.
- key_code, out, 8: scan code of the head entry.
- key_ext, out, 1: head entry was preceded by E0.
- key_break, out, 1: head entry was preceded by F0 (release).
- key_valid, out, 1: FIFO not empty.
- fifo_count, out, $clog2(FIFO_DEPTH+1): number of entries held.
- overflow, out, 1: sticky; an event was dropped because the FIFO was full.
- frame_err, out, 1: sticky; a parity, stop-bit or timeout error occurred.
- clear_err, in, 1: clears overflow and frame_err synchronously.

## Operation
- Input path: 2-FF synchroniser on each line, then a per-line saturating counter. A filtered line changes only after FILTER_LEN equal synchronised samples. An internal fall pulse is one cycle wide when filtered ps2_clk goes 1->0.
- Frame FSM, advancing only on fall:
  - IDLE: if dat=0 (start bit), go to DATA with bit count 0. If dat=1, stay in IDLE; this is not an error.
  - DATA: shift dat in LSB first. After 8 bits, go to PARITY.
  - PARITY: capture dat; the 9 bits must have odd parity.
  - STOP: dat must be 1. If stop and parity are both good, the byte goes to the decoder; otherwise set frame_err and discard the byte. In both cases return to IDLE.
- Timeout: in any state other than IDLE, a counter reloads on each fall. If it reaches TIMEOUT_CYCLES, set frame_err, go to IDLE and clear the prefix flags.
- Decoder:
  - 8'hE0 sets ext_pending.
  - 8'hF0 sets brk_pending.
  - Any other byte pushes {ext_pending, brk_pending, byte} into the FIFO and clears both flags.
  - A frame error also clears both flags.
- FIFO: show-ahead, so the outputs show the head entry combinationally from registered storage. When key_valid=0, the outputs hold their last value and are 0 after reset.
  - Push while full, without a pop in the same cycle: the entry is dropped and overflow is set.
  - Push and pop in the same cycle while full: both succeed and fifo_count is unchanged.
  - Push and pop in the same cycle while empty: only the push takes effect.
  - Pointers wrap modulo FIFO_DEPTH.
- clear_err on the same cycle as a new error: the error wins and the flag stays 1.
- Reset: async clear of every register.
  - FSM goes to IDLE, the FIFO is emptied, both flags clear.
  - Filtered lines reset to 1 (bus idle).
  - All outputs are 0.
  - Reset in the middle of a frame discards the partial frame. The receiver resynchronises on the next start bit once the bus has stayed high for FILTER_LEN cycles.

## Timing
- ps2_clk pin falling to fall pulse: 2 + FILTER_LEN cycles.
- fall of the stop bit to FIFO write: 1 cycle. key_valid rises 1 cycle after that write.
- rd_en pop: fifo_count and the head entry update on the next edge.
- Timeout compare uses >=, with the counter width $clog2(TIMEOUT_CYCLES+1).
- PS/2 bit period (60-100 µs) is much longer than FILTER_LEN cycles, so the filter never swallows a real edge.

## Structure
- Package ps2_pkg:
  - frame state enum: IDLE, DATA, PARITY, STOP;
  - constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0;
  - packed struct key_event_t {ext, brk, code[7:0]}.
- Sub-module ps2_event_fifo(DEPTH, WIDTH=10): sync show-ahead FIFO with full, empty and count.
- Synchroniser, filter, FSM and decoder sit in the top module.

## Test plan
- Send frame 8'h1C with good parity, bus model at 12.5 kHz -> one entry {0,0,1C}, key_valid=1, fifo_count=1. After rd_en, key_valid=0.
- Send E0, F0, 75 -> exactly one entry {ext=1, brk=1, 75}, and prefixes do not leak into the next key: 1C -> {0,0,1C}.
- Send byte 8'h29 with flipped parity -> no entry and frame_err=1. Then clear_err -> frame_err=0, and the next good frame is accepted.
- Send a start bit plus 4 bits, then hold the bus high for more than TIMEOUT_CYCLES -> frame_err=1 and the FSM is in IDLE. A following complete frame 8'h1B is received correctly.
- With FIFO_DEPTH=4 and no reads, send 5 keys -> fifo_count=4, overflow=1, and the 5th key is lost. Pushing a key in the same cycle as a rd_en while full keeps fifo_count at 4 and loses nothing.
- Assert resetn low mid-frame (after 5 data bits) -> all outputs 0. After release, a fresh frame 8'h5A yields entry {0,0,5A}.
